// File: rtl/tiny_pkg.sv
// Shared definitions for the tiny accumulator processor host memory loader:
// command opcodes, the error response byte and the loader state encoding.
package tiny_pkg;

  localparam logic [7:0] OP_SETA  = 8'h01;
  localparam logic [7:0] OP_WR    = 8'h02;
  localparam logic [7:0] OP_RD    = 8'h03;
  localparam logic [7:0] OP_RUN   = 8'h04;
  localparam logic [7:0] OP_HOLD  = 8'h05;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OPND = 3'd1,
    ST_MADR = 3'd2,
    ST_MWR  = 3'd3,
    ST_MRD  = 3'd4,
    ST_SEND = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

endpackage

// File: rtl/byte_shifter.sv
// NB-byte shift register: parallel load, byte shift-in at the LS end, and a
// count of bytes shifted since the last load.
module byte_shifter #(
  parameter int NB = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [NB*8-1:0]        load_data,
  input  logic                   shift,
  input  logic [7:0]             in_byte,
  output logic [NB*8-1:0]        data,
  output logic [$clog2(NB+1)-1:0] count
);

  localparam int DW = NB * 8;
  localparam int CW = $clog2(NB + 1);

  logic [DW-1:0] data_r;
  logic [CW-1:0] count_r;

  // Load restarts the byte count; a shift pushes one byte in from the LS side.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r  <= '0;
      count_r <= '0;
    end else if (load) begin
      data_r  <= load_data;
      count_r <= '0;
    end else if (shift) begin
      data_r  <= (data_r << 4'd8) | DW'(in_byte);
      count_r <= count_r + CW'(1'b1);
    end
  end

  assign data  = data_r;
  assign count = count_r;

endmodule

// File: rtl/mem_loader.sv
// Host-side memory port initiator: decodes a byte command stream into MI/RI
// cycles on the processor memory bus and streams read data back big-endian.
module mem_loader
  import tiny_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             MI,
  output logic             RI,
  output logic [WIDTH-1:0] write,
  input  logic [WIDTH-1:0] read,
  output logic             cpu_hold,
  output logic             busy
);

  localparam int NB = (WIDTH + 7) / 8;
  localparam int DW = NB * 8;
  localparam int CW = $clog2(NB + 1);

  state_t           state_r;
  logic [WIDTH-1:0] ptr_r;
  logic [WIDTH-1:0] write_r;
  logic             is_wr_r;
  logic             hold_r;
  logic             mi_r;
  logic             ri_r;
  logic             cmd_ready_r;
  logic             rsp_valid_r;

  logic             sh_load_s;
  logic [DW-1:0]    sh_load_data_s;
  logic             sh_shift_s;
  logic [7:0]       sh_in_s;
  logic [DW-1:0]    sh_data_s;
  logic [CW-1:0]    sh_count_s;
  logic [DW-1:0]    operand_next_s;
  logic             cmd_fire_s;
  logic             rsp_fire_s;
  logic             last_byte_s;

  byte_shifter #(.NB(NB)) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (sh_load_s),
    .load_data (sh_load_data_s),
    .shift     (sh_shift_s),
    .in_byte   (sh_in_s),
    .data      (sh_data_s),
    .count     (sh_count_s)
  );

  // Shifter control. Every accepted opcode preloads the error pattern, so ERR
  // needs no extra load and operand collection simply overwrites it.
  always_comb begin
    cmd_fire_s     = cmd_valid && cmd_ready_r;
    rsp_fire_s     = rsp_valid_r && rsp_ready;
    last_byte_s    = (sh_count_s == CW'(NB - 1));
    operand_next_s = (sh_data_s << 4'd8) | DW'(cmd_data);
    sh_load_s      = 1'b0;
    sh_load_data_s = '0;
    sh_shift_s     = 1'b0;
    sh_in_s        = 8'h00;
    case (state_r)
      ST_IDLE: begin
        if (cmd_fire_s) begin
          sh_load_s      = 1'b1;
          sh_load_data_s = DW'(ERR_BYTE) << (DW - 8);
        end else begin
          sh_load_s = 1'b0;
        end
      end
      ST_OPND: begin
        if (cmd_fire_s) begin
          sh_shift_s = 1'b1;
          sh_in_s    = cmd_data;
        end else begin
          sh_shift_s = 1'b0;
        end
      end
      ST_MRD: begin
        sh_load_s      = 1'b1;
        sh_load_data_s = DW'(read);
      end
      ST_SEND: begin
        if (rsp_fire_s) begin
          sh_shift_s = 1'b1;
        end else begin
          sh_shift_s = 1'b0;
        end
      end
      default: begin
        sh_load_s = 1'b0;
      end
    endcase
  end

  // Main loader FSM with the address pointer and all registered bus/stream outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      write_r     <= '0;
      is_wr_r     <= 1'b0;
      hold_r      <= 1'b1;
      mi_r        <= 1'b0;
      ri_r        <= 1'b0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_fire_s) begin
            case (cmd_data)
              OP_SETA: begin
                state_r <= ST_OPND;
                is_wr_r <= 1'b0;
              end
              OP_WR: begin
                if (hold_r) begin
                  state_r <= ST_OPND;
                  is_wr_r <= 1'b1;
                end else begin
                  state_r     <= ST_ERR;
                  cmd_ready_r <= 1'b0;
                  rsp_valid_r <= 1'b1;
                end
              end
              OP_RD: begin
                if (hold_r) begin
                  state_r     <= ST_MADR;
                  is_wr_r     <= 1'b0;
                  mi_r        <= 1'b1;
                  write_r     <= ptr_r;
                  cmd_ready_r <= 1'b0;
                end else begin
                  state_r     <= ST_ERR;
                  cmd_ready_r <= 1'b0;
                  rsp_valid_r <= 1'b1;
                end
              end
              OP_RUN:  hold_r <= 1'b0;
              OP_HOLD: hold_r <= 1'b1;
              default: begin
                state_r     <= ST_ERR;
                cmd_ready_r <= 1'b0;
                rsp_valid_r <= 1'b1;
              end
            endcase
          end
        end
        ST_OPND: begin
          if (cmd_fire_s && last_byte_s) begin
            if (is_wr_r) begin
              state_r     <= ST_MADR;
              mi_r        <= 1'b1;
              write_r     <= ptr_r;
              cmd_ready_r <= 1'b0;
            end else begin
              ptr_r   <= operand_next_s[WIDTH-1:0];
              state_r <= ST_IDLE;
            end
          end
        end
        ST_MADR: begin
          mi_r <= 1'b0;
          ri_r <= is_wr_r;
          if (is_wr_r) begin
            write_r <= sh_data_s[WIDTH-1:0];
            state_r <= ST_MWR;
          end else begin
            state_r <= ST_MRD;
          end
        end
        ST_MWR: begin
          ri_r        <= 1'b0;
          ptr_r       <= ptr_r + WIDTH'(1'b1);
          state_r     <= ST_IDLE;
          cmd_ready_r <= 1'b1;
        end
        ST_MRD: begin
          ptr_r       <= ptr_r + WIDTH'(1'b1);
          state_r     <= ST_SEND;
          rsp_valid_r <= 1'b1;
        end
        ST_SEND: begin
          if (rsp_fire_s && last_byte_s) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
          end
        end
        ST_ERR: begin
          if (rsp_fire_s) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          mi_r        <= 1'b0;
          ri_r        <= 1'b0;
          cmd_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Bus strobes are additionally gated by hold so the CPU can never collide with us.
  assign MI        = mi_r && hold_r;
  assign RI        = ri_r && hold_r;
  assign write     = write_r;
  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = sh_data_s[DW-1 -: 8];
  assign cpu_hold  = hold_r;
  assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: a 16-bit and an 8-bit instance, each on a
// small behavioural RAM with an address register.
module tb_mem_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [7:0] cmd_data  [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_data  [2];
  logic       mi        [2];
  logic       ri        [2];
  logic       cpu_hold  [2];
  logic       busy      [2];

  logic [15:0] write16, read16;
  logic [15:0] mar16 = 16'h0000;
  logic [7:0]  write8, read8;
  logic [7:0]  mar8 = 8'h00;
  logic [15:0] ram16 [0:65535];
  logic [7:0]  ram8  [0:255];
  int mi_cnt [2] = '{0, 0};
  int ri_cnt [2] = '{0, 0};
  int checks = 0;
  int errors = 0;
  int mb, rb;

  mem_loader #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_data(cmd_data[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .MI(mi[0]), .RI(ri[0]), .write(write16), .read(read16),
    .cpu_hold(cpu_hold[0]), .busy(busy[0])
  );

  mem_loader #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_data(cmd_data[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .MI(mi[1]), .RI(ri[1]), .write(write8), .read(read8),
    .cpu_hold(cpu_hold[1]), .busy(busy[1])
  );

  // Processor-side memory: MI latches the address, RI writes the word.
  always @(posedge clk) begin
    if (mi[0]) mar16 <= write16;
    if (ri[0]) ram16[mar16] <= write16;
    if (mi[1]) mar8 <= write8;
    if (ri[1]) ram8[mar8] <= write8;
    mi_cnt[0] <= mi_cnt[0] + (mi[0] ? 1 : 0);
    ri_cnt[0] <= ri_cnt[0] + (ri[0] ? 1 : 0);
    mi_cnt[1] <= mi_cnt[1] + (mi[1] ? 1 : 0);
    ri_cnt[1] <= ri_cnt[1] + (ri[1] ? 1 : 0);
  end

  assign read16 = ram16[mar16];
  assign read8  = ram8[mar8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one command byte; returns 1 time unit after the accepting edge.
  task automatic send(input int s, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    cmd_valid[s] = 1'b1;
    cmd_data[s]  = b;
    while (!cmd_ready[s] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid[s] = 1'b0;
  endtask

  task automatic recv(input int s, input logic [7:0] exp, input string tag);
    int n = 0;
    @(negedge clk);
    rsp_ready[s] = 1'b1;
    while (!rsp_valid[s] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(rsp_valid[s]), 32'd1);
    chk(tag, 32'(rsp_data[s]), 32'(exp));
    @(posedge clk);
    #1;
    rsp_ready[s] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      cmd_data[i]  = 8'h00;
      rsp_ready[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst8_hold", 32'(cpu_hold[1]), 32'd1);
    chk("rst8_cmd_ready", 32'(cmd_ready[1]), 32'd1);
    chk("rst8_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("rst8_mi_ri", {30'd0, mi[1], ri[1]}, 32'd0);
    chk("rst8_busy", 32'(busy[1]), 32'd0);
    chk("rst16_hold", 32'(cpu_hold[0]), 32'd1);
    chk("rst16_rsp_data", 32'(rsp_data[0]), 32'd0);
    chk("rst16_write", 32'(write16), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // W16: ram[0x0000] = 0xBEEF, then WR 0x0041 to 0x0064 with cycle timing.
    send(0, 8'h01); send(0, 8'h00); send(0, 8'h00);
    send(0, 8'h02); send(0, 8'hBE); send(0, 8'hEF);
    send(0, 8'h01); send(0, 8'h00); send(0, 8'h64);
    send(0, 8'h02); send(0, 8'h00); send(0, 8'h41);
    chk("wr_mi", {30'd0, mi[0], ri[0]}, 32'd2);
    chk("wr_mi_addr", 32'(write16), 32'h0064);
    chk("wr_cmd_ready_low", 32'(cmd_ready[0]), 32'd0);
    @(posedge clk); #1;
    chk("wr_ri", {30'd0, mi[0], ri[0]}, 32'd1);
    chk("wr_ri_data", 32'(write16), 32'h0041);
    @(posedge clk); #1;
    chk("wr_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk("wr_ram", 32'(ram16[16'h0064]), 32'h0041);
    chk("wr_ram0", 32'(ram16[16'h0000]), 32'hBEEF);

    // W16: RD timing from the opcode edge.
    send(0, 8'h01); send(0, 8'h00); send(0, 8'h64);
    send(0, 8'h03);
    chk("rd_mi", 32'(mi[0]), 32'd1);
    chk("rd_mi_addr", 32'(write16), 32'h0064);
    @(posedge clk); #1;
    chk("rd_capture", {30'd0, mi[0], rsp_valid[0]}, 32'd0);
    @(posedge clk); #1;
    chk("rd_first_valid", 32'(rsp_valid[0]), 32'd1);
    recv(0, 8'h00, "rd_b0");
    recv(0, 8'h41, "rd_b1");
    chk("rd_done", {30'd0, rsp_valid[0], busy[0]}, 32'd0);

    // W8: pointer wrap on write and read.
    send(1, 8'h01); send(1, 8'hFF);
    send(1, 8'h02); send(1, 8'h12);
    send(1, 8'h02); send(1, 8'h34);
    repeat (3) @(posedge clk); #1;
    chk("wrap_ram_ff", 32'(ram8[8'hFF]), 32'h12);
    chk("wrap_ram_00", 32'(ram8[8'h00]), 32'h34);
    send(1, 8'h01); send(1, 8'hFF);
    send(1, 8'h03);
    recv(1, 8'h12, "wrap_rd_ff");
    send(1, 8'h03);
    recv(1, 8'h34, "wrap_rd_00");

    // W16: backpressure holds rsp_data and issues exactly one memory read.
    send(0, 8'h01); send(0, 8'h00); send(0, 8'h64);
    mb = mi_cnt[0];
    rb = ri_cnt[0];
    send(0, 8'h03);
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid0", 32'(rsp_valid[0]), 32'd1);
      chk("bp_hold0", 32'(rsp_data[0]), 32'h00);
      @(posedge clk); #1;
    end
    recv(0, 8'h00, "bp_b0");
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold1", 32'(rsp_data[0]), 32'h41);
      @(posedge clk); #1;
    end
    recv(0, 8'h41, "bp_b1");
    chk("bp_one_mi", 32'(mi_cnt[0] - mb), 32'd1);
    chk("bp_no_ri", 32'(ri_cnt[0] - rb), 32'd0);

    // W8: unknown opcode, RUN then WR, HOLD.
    mb = mi_cnt[1];
    rb = ri_cnt[1];
    send(1, 8'h7A);
    recv(1, 8'hEE, "bad_op");
    chk("bad_op_single", 32'(rsp_valid[1]), 32'd0);
    send(1, 8'h04);
    chk("run_hold", 32'(cpu_hold[1]), 32'd0);
    send(1, 8'h02);
    recv(1, 8'hEE, "run_wr");
    chk("run_wr_hold", 32'(cpu_hold[1]), 32'd0);
    chk("err_no_mi", 32'(mi_cnt[1] - mb), 32'd0);
    chk("err_no_ri", 32'(ri_cnt[1] - rb), 32'd0);
    send(1, 8'h05);
    chk("hold_hold", 32'(cpu_hold[1]), 32'd1);

    // W16: reset in the middle of a response drops everything at once.
    send(0, 8'h01); send(0, 8'h00); send(0, 8'h64);
    send(0, 8'h03);
    recv(0, 8'h00, "rst_b0");
    chk("rst_pre_valid", 32'(rsp_valid[0]), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_async_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_async_busy", 32'(busy[0]), 32'd0);
    chk("rst_async_hold", 32'(cpu_hold[0]), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_post_idle", {29'd0, busy[0], rsp_valid[0], cmd_ready[0]}, 32'd1);
    send(0, 8'h03);
    recv(0, 8'hBE, "rst_ptr_b0");
    recv(0, 8'hEF, "rst_ptr_b1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
